mem_arbiter2: RTL
=================

Name: mem_arbiter2

Overview:
- Two-master arbiter for the single shared accelerator memory port: 16-bit halfword address, 32-bit word data, en/we strobes, read data one cycle after request.
- Lets two engines (e.g. the inversion pass and the edge-detection pass) share one memory without external sequencing.
- Round-robin on contention, optional lock for uninterrupted bursts, per-master grant counters for performance checks.

Parameters:
- ADDR_W, 16, address width (halfword_t).
- DATA_W, 32, data width (word_t).
- CNT_W, 16, width of the per-master saturating grant counters.

Ports:
- clk  input  1  clock.
- reset  input  1  reset.
- m0_req  input  1  master 0 requests an access this cycle.
- m0_lock  input  1  master 0 asks to keep ownership after this access.
- m0_we  input  1  master 0 write (1) / read (0).
- m0_addr  input  ADDR_W  master 0 address.
- m0_dataW  input  DATA_W  master 0 write data.
- m0_gnt  output  1  master 0 access accepted this cycle (combinational).
- m0_rvalid  output  1  master 0 read data valid on m0_dataR.
- m0_dataR  output  DATA_W  read data to master 0.
- m1_req, m1_lock, m1_we, m1_addr, m1_dataW, m1_gnt, m1_rvalid, m1_dataR: same as master 0, for master 1.
- addr  output  ADDR_W  memory address.
- dataR  input  DATA_W  memory read data, valid the cycle after a read request.
- dataW  output  DATA_W  memory write data.
- en  output  1  memory request.
- we  output  1  memory write enable.
- m0_gnt_cnt  output  CNT_W  granted cycles for master 0.
- m1_gnt_cnt  output  CNT_W  granted cycles for master 1.

Behaviour:
- Reset (already decided): reset is asynchronous and active-high; the clock is clk.
- On reset:
  - state=FREE, last_gnt=1, so master 0 wins the first tie.
  - m0_rvalid=m1_rvalid=0; both counters=0.
  - With no request: en=0, we=0, addr=0, dataW=0, both gnt=0.
- Grant logic is combinational from the registered state/last_gnt and the current req inputs.
  - At most one gnt is high per cycle.
  - A requester that sees gnt=0 holds req, we, addr and dataW stable until granted.
- Memory mux:
  - When gnt_i=1: en=1, we=mi_we, addr=mi_addr, dataW=mi_dataW.
  - With no grant: en=0, we=0, addr=0, dataW=0.
- State machine (FREE, OWN0, OWN1):
  - FREE, one requester: grant it.
  - FREE, both requesters: grant the master != last_gnt.
  - FREE, no request: no grant; state holds.
  - FREE -> OWNi at the clock edge when master i is granted with mi_lock=1.
  - OWNi: grant i whenever mi_req=1. The other master is never granted in OWNi, including the cycle where lock drops.
  - OWNi -> FREE at the edge of any cycle with mi_lock=0, whether or not mi_req=1 that cycle.
- last_gnt updates to i on every edge where gnt_i=1; unchanged on idle cycles.
- Read return:
  - mi_rvalid is registered: it is 1 in cycle t+1 iff gnt_i=1 and mi_we=0 in cycle t.
  - m0_dataR and m1_dataR both carry dataR combinationally; masters qualify it with rvalid.
  - Latency is exactly 1 cycle, the same as the direct memory.
  - Back-to-back grants to different masters give back-to-back rvalids to the correct masters.
- Writes produce no rvalid.
- Counters: mi_gnt_cnt increments on each edge where gnt_i=1 and saturates at all-ones (0xFFFF); it never wraps.
- Simultaneous lock requests in FREE: only the winner enters OWN; the loser's lock is ignored until it is granted.
- Reset mid-burst or with a read outstanding:
  - State returns to FREE and the pending rvalid is dropped (0 after reset).
  - Counters clear.
  - Outputs follow the reset values immediately, since reset is asynchronous.

Test Plan:
- Read path: m0 alone reads addr 0x0010 while memory returns 0xDEADBEEF -> m0_gnt=1 and en=1, we=0, addr=0x0010 the same cycle; next cycle m0_rvalid=1, m0_dataR=0xDEADBEEF, m1_rvalid=0.
- Contention: both masters request continuously for 6 cycles after reset -> grants 0,1,0,1,0,1; each rvalid lands the cycle after its own grant; both counters read 3.
- Lock burst: m1 is granted with lock=1 for 4 reads, m0 requesting throughout, m1 drops lock on its 4th access -> m0_gnt=0 during those 4 cycles; m0 is granted on the 5th cycle.
- Write path: m1 writes 0x12345678 to 0x6300 -> en=1, we=1, addr=0x6300, dataW=0x12345678 the same cycle; no rvalid follows.
- Saturation: m0 requests for 65540 cycles -> m0_gnt_cnt stops at 0xFFFF; m1_gnt_cnt=0.
- Reset in OWN0 with a read outstanding: assert reset between clock edges -> gnt, en and rvalid go 0 immediately; after release, with both masters requesting, m0 wins the first grant.

Source files
------------

// File: rtl/mem_arbiter2_if.sv
// mem_arbiter2_if: bundles the two master request/response ports and the
// shared memory port served by mem_arbiter2.
//   m0_* / m1_* : req, lock, we, addr, dataW from each master; gnt, rvalid,
//                 dataR back to each master.
//   addr, dataW, en, we : request side of the shared memory port.
//   dataR               : memory read data, valid one cycle after a read.
// Modports:
//   slave  - the arbiter's view.
//   master - the masters plus the memory model (the arbiter's environment).
interface mem_arbiter2_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_lock;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_dataW;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_dataR;

  logic              m1_req;
  logic              m1_lock;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_dataW;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_dataR;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dataR;
  logic [DATA_W-1:0] dataW;
  logic              en;
  logic              we;

  modport slave (
    input  m0_req, m0_lock, m0_we, m0_addr, m0_dataW,
    output m0_gnt, m0_rvalid, m0_dataR,
    input  m1_req, m1_lock, m1_we, m1_addr, m1_dataW,
    output m1_gnt, m1_rvalid, m1_dataR,
    output addr, dataW, en, we,
    input  dataR
  );

  modport master (
    output m0_req, m0_lock, m0_we, m0_addr, m0_dataW,
    input  m0_gnt, m0_rvalid, m0_dataR,
    output m1_req, m1_lock, m1_we, m1_addr, m1_dataW,
    input  m1_gnt, m1_rvalid, m1_dataR,
    input  addr, dataW, en, we,
    output dataR
  );
endinterface

// File: rtl/mem_arbiter2.sv
// mem_arbiter2: two-master arbiter for one shared single-port memory.
// Round-robin on contention, optional lock so a master can keep the port
// for an uninterrupted burst, and per-master saturating grant counters.
//
// Ports:
//   clk        - clock
//   reset      - asynchronous, active-high reset
//   bus        - mem_arbiter2_if.slave (both master ports + memory port)
//   m0_gnt_cnt - number of cycles master 0 was granted (saturating)
//   m1_gnt_cnt - number of cycles master 1 was granted (saturating)
//
// Grants are combinational from the registered state and the current
// requests; read data returns on the cycle after the grant.
//
// state | meaning
// FREE  | no owner; round-robin between requesters
// OWN0  | master 0 holds the port via lock; only master 0 may be granted
// OWN1  | master 1 holds the port via lock; only master 1 may be granted
module mem_arbiter2 #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  mem_arbiter2_if.slave    bus,
  output logic [CNT_W-1:0] m0_gnt_cnt,
  output logic [CNT_W-1:0] m1_gnt_cnt
);

  typedef enum logic [1:0] {
    FREE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state, state_nxt;
  logic   last_gnt;      // 0: master 0 was granted last, 1: master 1
  logic   gnt0, gnt1;
  logic   rvalid0, rvalid1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FREE;
      last_gnt <= 1'b1;
    end else begin
      state <= state_nxt;
      if (gnt0)
        last_gnt <= 1'b0;
      else if (gnt1)
        last_gnt <= 1'b1;
    end
  end

  // Grants are forced low while reset is asserted so the memory port and
  // the masters see an idle bus immediately, not only after the next edge.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_nxt = state;
    unique case (state)
      FREE: begin
        if (bus.m0_req && bus.m1_req) begin
          if (last_gnt)
            gnt0 = 1'b1;
          else
            gnt1 = 1'b1;
        end else if (bus.m0_req) begin
          gnt0 = 1'b1;
        end else if (bus.m1_req) begin
          gnt1 = 1'b1;
        end
        // Only the winner's lock counts; the loser's lock waits for its grant.
        if (gnt0 && bus.m0_lock)
          state_nxt = OWN0;
        else if (gnt1 && bus.m1_lock)
          state_nxt = OWN1;
      end
      OWN0: begin
        gnt0 = bus.m0_req;
        // Ownership ends on any cycle with lock low, request or not.
        if (!bus.m0_lock)
          state_nxt = FREE;
      end
      OWN1: begin
        gnt1 = bus.m1_req;
        if (!bus.m1_lock)
          state_nxt = FREE;
      end
      default: state_nxt = FREE;
    endcase
    if (reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  assign bus.m0_gnt = gnt0;
  assign bus.m1_gnt = gnt1;

  always_comb begin
    bus.en    = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.dataW = '0;
    if (gnt0) begin
      bus.en    = 1'b1;
      bus.we    = bus.m0_we;
      bus.addr  = bus.m0_addr;
      bus.dataW = bus.m0_dataW;
    end else if (gnt1) begin
      bus.en    = 1'b1;
      bus.we    = bus.m1_we;
      bus.addr  = bus.m1_addr;
      bus.dataW = bus.m1_dataW;
    end
  end

  // Read return: memory data is shared, rvalid steers it to the owner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= gnt0 && !bus.m0_we;
      rvalid1 <= gnt1 && !bus.m1_we;
    end
  end

  assign bus.m0_rvalid = rvalid0;
  assign bus.m1_rvalid = rvalid1;
  assign bus.m0_dataR  = bus.dataR;
  assign bus.m1_dataR  = bus.dataR;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_gnt_cnt <= '0;
      m1_gnt_cnt <= '0;
    end else begin
      if (gnt0 && (m0_gnt_cnt != CNT_MAX))
        m0_gnt_cnt <= m0_gnt_cnt + 1'b1;
      if (gnt1 && (m1_gnt_cnt != CNT_MAX))
        m1_gnt_cnt <= m1_gnt_cnt + 1'b1;
    end
  end

endmodule
